// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, condition codes and register IDs.
// Also provides the condition evaluation used by cmovXX/jXX.
package y86_pkg;

   localparam logic [3:0] IHalt   = 4'h0;
   localparam logic [3:0] INop    = 4'h1;
   localparam logic [3:0] IRrmovq = 4'h2;
   localparam logic [3:0] IIrmovq = 4'h3;
   localparam logic [3:0] IRmmovq = 4'h4;
   localparam logic [3:0] IMrmovq = 4'h5;
   localparam logic [3:0] IOpq    = 4'h6;
   localparam logic [3:0] IJxx    = 4'h7;
   localparam logic [3:0] ICall   = 4'h8;
   localparam logic [3:0] IRet    = 4'h9;
   localparam logic [3:0] IPushq  = 4'hA;
   localparam logic [3:0] IPopq   = 4'hB;

   localparam logic [3:0] AluAdd = 4'h0;
   localparam logic [3:0] AluSub = 4'h1;
   localparam logic [3:0] AluAnd = 4'h2;
   localparam logic [3:0] AluXor = 4'h3;

   localparam logic [3:0] CYes = 4'h0;
   localparam logic [3:0] CLe  = 4'h1;
   localparam logic [3:0] CL   = 4'h2;
   localparam logic [3:0] CE   = 4'h3;
   localparam logic [3:0] CNe  = 4'h4;
   localparam logic [3:0] CGe  = 4'h5;
   localparam logic [3:0] CG   = 4'h6;

   localparam logic [3:0] RRsp  = 4'h4;
   localparam logic [3:0] RNone = 4'hF;
   localparam int         NumRegs = 15;

   function automatic logic cond_eval(input logic [3:0] fn, input logic zf, input logic sf,
                                      input logic of);
      logic lt;
      lt = sf ^ of;
      case (fn)
         CYes:    return 1'b1;
         CLe:     return lt | zf;
         CL:      return lt;
         CE:      return zf;
         CNe:     return !zf;
         CGe:     return !lt;
         CG:      return !lt && !zf;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file, two async read ports and two sync write ports (M port wins).
// Optional flat dump output when RF_DUMP_EN is defined.
module y86_regfile
   import y86_pkg::*;
#(
   parameter logic [63:0] RspReset = 64'd0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [3:0]  i_src_a,
   input  logic [3:0]  i_src_b,
   output logic [63:0] o_val_a,
   output logic [63:0] o_val_b,
   input  logic [3:0]  i_dst_e,
   input  logic [63:0] i_val_e,
   input  logic [3:0]  i_dst_m,
`ifdef RF_DUMP_EN
   output logic [64*NumRegs-1:0] o_dump,
`endif
   input  logic [63:0] i_val_m
);

   logic [63:0] r_regs [NumRegs];

   // M write is issued last so it overrides E on popq %rsp.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NumRegs; i++) begin
            r_regs[i] <= (i == int'(RRsp)) ? RspReset : 64'd0;
         end
      end else begin
         if (i_dst_e != RNone) r_regs[i_dst_e] <= i_val_e;
         if (i_dst_m != RNone) r_regs[i_dst_m] <= i_val_m;
      end
   end

   assign o_val_a = (i_src_a == RNone) ? 64'd0 : r_regs[i_src_a];
   assign o_val_b = (i_src_b == RNone) ? 64'd0 : r_regs[i_src_b];

`ifdef RF_DUMP_EN
   for (genvar g = 0; g < NumRegs; g++) begin : g_dump
      assign o_dump[64*g +: 64] = r_regs[g];
   end
`endif

endmodule

// File: rtl/y86_decode_exec_pc.sv
// Y86-64 single-cycle decode/execute/write-back/PC-select slice with condition codes.
// Define RF_DUMP_EN to expose the whole register file on rf_dump.
module y86_decode_exec_pc
   import y86_pkg::*;
#(
   parameter logic [63:0] RSP_RESET = 64'd0
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef RF_DUMP_EN
   output logic [64*NumRegs-1:0] rf_dump,
`endif
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic [63:0] valC,
   input  logic [63:0] valP,
   input  logic [63:0] valM,
   output logic [63:0] valA,
   output logic [63:0] valB,
   output logic [63:0] valE,
   output logic        ZF,
   output logic        SF,
   output logic        OF,
   output logic        Cnd,
   output logic [63:0] PC_next
);

   logic [3:0] w_src_a, w_src_b, w_dst_e, w_dst_m;
   logic       w_of;
   logic       r_zf, r_sf, r_of;

   always_comb begin
      w_src_a = RNone;
      w_src_b = RNone;
      w_dst_e = RNone;
      w_dst_m = RNone;
      case (icode)
         IRrmovq: begin w_src_a = rA; if (Cnd) w_dst_e = rB; end
         IIrmovq: w_dst_e = rB;
         IRmmovq: begin w_src_a = rA; w_src_b = rB; end
         IMrmovq: begin w_src_b = rB; w_dst_m = rA; end
         IOpq:    begin w_src_a = rA; w_src_b = rB; w_dst_e = rB; end
         ICall:   begin w_src_b = RRsp; w_dst_e = RRsp; end
         IRet:    begin w_src_a = RRsp; w_src_b = RRsp; w_dst_e = RRsp; end
         IPushq:  begin w_src_a = rA; w_src_b = RRsp; w_dst_e = RRsp; end
         IPopq:   begin w_src_a = RRsp; w_src_b = RRsp; w_dst_e = RRsp; w_dst_m = rA; end
         default: ;
      endcase
   end

   y86_regfile #(
      .RspReset (RSP_RESET)
   ) u_regfile (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_src_a (w_src_a),
      .i_src_b (w_src_b),
      .o_val_a (valA),
      .o_val_b (valB),
      .i_dst_e (w_dst_e),
      .i_val_e (valE),
      .i_dst_m (w_dst_m),
`ifdef RF_DUMP_EN
      .o_dump  (rf_dump),
`endif
      .i_val_m (valM)
   );

   // Overflow: operands agree in sign (add) or differ (sub) and the result flips from valB.
   always_comb begin
      valE = 64'd0;
      w_of = 1'b0;
      case (icode)
         IRrmovq:          valE = valA;
         IIrmovq:          valE = valC;
         IRmmovq, IMrmovq: valE = valB + valC;
         IOpq: begin
            case (ifun)
               AluAdd: begin
                  valE = valB + valA;
                  w_of = (valB[63] == valA[63]) && (valE[63] != valB[63]);
               end
               AluSub: begin
                  valE = valB - valA;
                  w_of = (valB[63] != valA[63]) && (valE[63] != valB[63]);
               end
               AluAnd:  valE = valB & valA;
               AluXor:  valE = valB ^ valA;
               default: ;
            endcase
         end
         ICall, IPushq: valE = valB - 64'd8;
         IRet, IPopq:   valE = valB + 64'd8;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zf <= 1'b1;
         r_sf <= 1'b0;
         r_of <= 1'b0;
      end else if (icode == IOpq) begin
         r_zf <= (valE == 64'd0);
         r_sf <= valE[63];
         r_of <= w_of;
      end
   end

   assign ZF  = r_zf;
   assign SF  = r_sf;
   assign OF  = r_of;
   assign Cnd = cond_eval(ifun, r_zf, r_sf, r_of);

   always_comb begin
      case (icode)
         ICall:   PC_next = valC;
         IJxx:    PC_next = Cnd ? valC : valP;
         IRet:    PC_next = valM;
         default: PC_next = valP;
      endcase
   end

endmodule

// File: tb/tb_y86_decode_exec_pc.sv
// Randomized self-checking bench for y86_decode_exec_pc against an instruction-level model.
module tb_y86_decode_exec_pc;

   localparam logic [63:0] RspInit = 64'h0000_0000_0000_0f00;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  icode = '0, ifun = '0, rA = 4'hf, rB = 4'hf;
   logic [63:0] valC = '0, valP = '0, valM = '0;
   logic [63:0] valA, valB, valE, PC_next;
   logic        ZF, SF, OF, Cnd;
`ifdef RF_DUMP_EN
   logic [959:0] rf_dump;
`endif

   y86_decode_exec_pc #(
      .RSP_RESET (RspInit)
   ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef RF_DUMP_EN
      .rf_dump (rf_dump),
`endif
      .icode   (icode),
      .ifun    (ifun),
      .rA      (rA),
      .rB      (rB),
      .valC    (valC),
      .valP    (valP),
      .valM    (valM),
      .valA    (valA),
      .valB    (valB),
      .valE    (valE),
      .ZF      (ZF),
      .SF      (SF),
      .OF      (OF),
      .Cnd     (Cnd),
      .PC_next (PC_next)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [63:0] m_reg [15];
   logic        m_zf, m_sf, m_of;
   logic [63:0] obs_vala, obs_valb, obs_vale, obs_pc;
   logic        obs_cnd;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 15; i++) m_reg[i] = (i == 4) ? RspInit : 64'd0;
      m_zf = 1'b1;
      m_sf = 1'b0;
      m_of = 1'b0;
   endtask

   function automatic logic [63:0] rd(input logic [3:0] id);
      if (id == 4'hf) return 64'd0;
      return m_reg[id];
   endfunction

   function automatic logic cond_ok(input logic [3:0] f);
      logic lt;
      lt = m_sf ^ m_of;
      case (f)
         4'd0:    return 1'b1;
         4'd1:    return lt | m_zf;
         4'd2:    return lt;
         4'd3:    return m_zf;
         4'd4:    return !m_zf;
         4'd5:    return !lt;
         4'd6:    return !lt && !m_zf;
         default: return 1'b0;
      endcase
   endfunction

   // Drive one instruction at a negedge, check combinational results, clock it, check flags.
   task automatic apply(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] c, input logic [63:0] p,
                        input logic [63:0] m);
      logic [63:0] ea, eb, ee, epc;
      logic        ec, set_cc, of;
      logic [3:0]  de, dm;
      logic [64:0] wide;
      icode = ic; ifun = fn; rA = ra; rB = rb; valC = c; valP = p; valM = m;
      #1;
      ea = '0; eb = '0; ee = '0; epc = p; ec = cond_ok(fn);
      de = 4'hf; dm = 4'hf; set_cc = 1'b0; of = 1'b0; wide = '0;
      case (ic)
         4'h2: begin ea = rd(ra); ee = ea; if (ec) de = rb; end
         4'h3: begin ee = c; de = rb; end
         4'h4: begin ea = rd(ra); eb = rd(rb); ee = eb + c; end
         4'h5: begin eb = rd(rb); ee = eb + c; dm = ra; end
         4'h6: begin
            ea = rd(ra); eb = rd(rb); de = rb; set_cc = 1'b1;
            case (fn)
               4'd0: begin wide = {eb[63], eb} + {ea[63], ea}; ee = wide[63:0];
                           of = wide[64] ^ wide[63]; end
               4'd1: begin wide = {eb[63], eb} - {ea[63], ea}; ee = wide[63:0];
                           of = wide[64] ^ wide[63]; end
               4'd2: ee = eb & ea;
               4'd3: ee = eb ^ ea;
               default: ee = '0;
            endcase
         end
         4'h7: if (ec) epc = c;
         4'h8: begin eb = m_reg[4]; ee = eb - 64'd8; de = 4'd4; epc = c; end
         4'h9: begin ea = m_reg[4]; eb = ea; ee = eb + 64'd8; de = 4'd4; epc = m; end
         4'hA: begin ea = rd(ra); eb = m_reg[4]; ee = eb - 64'd8; de = 4'd4; end
         4'hB: begin ea = m_reg[4]; eb = ea; ee = eb + 64'd8; de = 4'd4; dm = ra; end
         default: ;
      endcase
      obs_vala = valA; obs_valb = valB; obs_vale = valE; obs_pc = PC_next; obs_cnd = Cnd;
      check_eq($sformatf("valA ic=%h", ic), valA, ea);
      check_eq($sformatf("valB ic=%h", ic), valB, eb);
      check_eq($sformatf("valE ic=%h fn=%h", ic, fn), valE, ee);
      check_eq($sformatf("Cnd fn=%h", fn), {63'd0, Cnd}, {63'd0, ec});
      check_eq($sformatf("PC_next ic=%h", ic), PC_next, epc);
      @(posedge clk);
      if (rst_n) begin
         if (de != 4'hf) m_reg[de] = ee;
         if (dm != 4'hf) m_reg[dm] = m;
         if (set_cc) begin
            m_zf = (ee == 64'd0);
            m_sf = ee[63];
            m_of = of;
         end
      end
      #1;
      check_eq("ZF", {63'd0, ZF}, {63'd0, m_zf});
      check_eq("SF", {63'd0, SF}, {63'd0, m_sf});
      check_eq("OF", {63'd0, OF}, {63'd0, m_of});
      @(negedge clk);
   endtask

   // Assert reset between edges, then attempt writes to every register while it is held.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("rst_ZF", {63'd0, ZF}, 64'd1);
      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         apply(4'h6, 4'h0, 4'(i), 4'(i), 64'd0, 64'h10, 64'd0);
      end
      rst_n = 1'b1;
   endtask

   function automatic logic [63:0] rand_val();
      logic [63:0] edges [6];
      edges[0] = 64'h8000_0000_0000_0000; edges[1] = 64'h7fff_ffff_ffff_ffff;
      edges[2] = 64'hffff_ffff_ffff_ffff; edges[3] = 64'd0;
      edges[4] = 64'd1;                   edges[5] = 64'd8;
      case ($urandom_range(0, 3))
         0:       return {$urandom, $urandom};
         1:       return 64'($urandom_range(0, 300));
         2:       return edges[$urandom_range(0, 5)];
         default: return {32'd0, $urandom};
      endcase
   endfunction

   initial begin
      logic [3:0] ic, fn;
      model_reset();
      @(negedge clk);
      do_reset();

      apply(4'h3, 4'h0, 4'hf, 4'd2, 64'd120, 64'h40, 64'd0);
      check_eq("r29_pc", obs_pc, 64'h40);
      apply(4'h4, 4'h0, 4'd2, 4'hf, 64'd0, 64'h48, 64'd0);
      check_eq("r29_reg2", obs_vala, 64'd120);

      apply(4'h3, 4'h0, 4'hf, 4'd1, 64'd100, 64'h50, 64'd0);
      apply(4'h3, 4'h0, 4'hf, 4'd5, 64'd4, 64'h58, 64'd0);
      apply(4'h6, 4'h0, 4'd1, 4'd5, 64'd0, 64'h60, 64'd0);
      check_eq("r30_valE", obs_vale, 64'd104);
      check_eq("r30_flags", {61'd0, ZF, SF, OF}, 64'd0);
      apply(4'h4, 4'h0, 4'd5, 4'hf, 64'd0, 64'h68, 64'd0);
      check_eq("r30_reg5", obs_vala, 64'd104);

      apply(4'h3, 4'h0, 4'hf, 4'd1, 64'd1, 64'h70, 64'd0);
      apply(4'h3, 4'h0, 4'hf, 4'd5, 64'h8000_0000_0000_0000, 64'h78, 64'd0);
      apply(4'h6, 4'h1, 4'd1, 4'd5, 64'd0, 64'h80, 64'd0);
      check_eq("r31_flags", {61'd0, ZF, SF, OF}, 64'd1);
      apply(4'h7, 4'h2, 4'hf, 4'hf, 64'h500, 64'h88, 64'd0);
      check_eq("r31_cnd", {63'd0, obs_cnd}, 64'd1);
      check_eq("r31_pc", obs_pc, 64'h500);

      apply(4'h3, 4'h0, 4'hf, 4'd4, 64'd200, 64'h90, 64'd0);
      apply(4'hA, 4'h0, 4'd1, 4'hf, 64'd0, 64'h98, 64'd0);
      check_eq("r32_push_valE", obs_vale, 64'd192);
      apply(4'hB, 4'h0, 4'd3, 4'hf, 64'd0, 64'ha0, 64'd5);
      apply(4'h4, 4'h0, 4'd3, 4'd4, 64'd0, 64'ha8, 64'd0);
      check_eq("r32_reg3", obs_vala, 64'd5);
      check_eq("r32_rsp", obs_valb, 64'd200);

      apply(4'h8, 4'h0, 4'hf, 4'hf, 64'd80, 64'hb0, 64'd0);
      check_eq("r33_call_pc", obs_pc, 64'd80);
      apply(4'h4, 4'h0, 4'd4, 4'hf, 64'd0, 64'hb8, 64'd0);
      check_eq("r33_rsp", obs_vala, 64'd192);
      apply(4'h9, 4'h0, 4'hf, 4'hf, 64'd0, 64'hc0, 64'd69);
      check_eq("r33_ret_pc", obs_pc, 64'd69);

      apply(4'hB, 4'h0, 4'd4, 4'hf, 64'd0, 64'hc8, 64'h1234);
      apply(4'h4, 4'h0, 4'd4, 4'hf, 64'd0, 64'hd0, 64'd0);
      check_eq("popq_rsp", obs_vala, 64'h1234);

      apply(4'h3, 4'h0, 4'hf, 4'd7, 64'd77, 64'hd8, 64'd0);
      do_reset();
      apply(4'h2, 4'h6, 4'd1, 4'd7, 64'd0, 64'he0, 64'd0);
      check_eq("r34_cnd", {63'd0, obs_cnd}, 64'd0);
      apply(4'h4, 4'h0, 4'd7, 4'd4, 64'd0, 64'he8, 64'd0);
      check_eq("r34_reg7", obs_vala, 64'd0);
      check_eq("r34_rsp", obs_valb, RspInit);

      for (int n = 0; n < 600; n++) begin
         if (n % 200 == 199) do_reset();
         ic = 4'($urandom_range(0, 15));
         fn = (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         apply(ic, fn, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rand_val(),
               {$urandom, $urandom}, rand_val());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/y86_decode_exec_pc.md
Y86_DECODE_EXEC_PC -- requirements
Module: y86_decode_exec_pc

Interface
REQ-001 SHALL be one clock domain; reset is asynchronous and active-low.
REQ-002 Parameter RSP_RESET, default 64'd0, reset value of register 4 (%rsp).
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Ports icode, ifun, rA, rB  input  4 each  fetched instruction fields.
REQ-006 Ports valC, valP  input  64 each  constant and fall-through PC.
REQ-007 Port valM  input  64  data-memory read value.
REQ-008 Ports valA, valB, valE  output  64 each  signed operands and ALU result.
REQ-009 Ports ZF, SF, OF  output  1 each  condition-code register.
REQ-010 Port Cnd  output  1  condition result.
REQ-011 Port PC_next  output  64  next PC.

Function
REQ-012 Register file SHALL hold 15 x 64-bit registers, IDs 0..14; ID 0xF means "none" (reads 0, writes ignored).
REQ-013 srcA: rA for icode 2, 4, 6, A; %rsp (4) for 9, B; else none.
REQ-014 srcB: rB for icode 4, 5, 6; %rsp for 8, 9, A, B; else none.
REQ-015 valA/valB SHALL be combinational reads of srcA/srcB.
REQ-016 valE (combinational): 2 -> valA; 3 -> valC; 4, 5 -> valB+valC; 6 -> valB op valA (ifun 0 add, 1 sub valB-valA, 2 and, 3 xor); 8, A -> valB-8; 9, B -> valB+8; else 0.
REQ-017 ZF/SF/OF SHALL update on rising clk only when icode=6: ZF=(valE==0); SF=valE[63]; OF = signed overflow of add/sub, 0 for and/xor.
REQ-018 Cnd from registered flags by ifun: 0 always 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 !ZF; 5 !(SF^OF); 6 !(SF^OF)&!ZF; others 0.
REQ-019 Write-back on rising clk: dstE = rB for icode 2 (only if Cnd) and 3, 6; %rsp for 8, 9, A, B; dstM = rA for 5, B.
REQ-020 When dstE==dstM (popq %rsp), valM SHALL win.
REQ-021 PC_next (combinational): 8 -> valC; 7 with Cnd -> valC; 9 -> valM; else valP.
REQ-022 Unknown icode (>B): no register/flag write; valE=0; PC_next=valP.
REQ-023 Arithmetic SHALL be 64-bit two's complement wrap-around.

Reset
REQ-024 rst_n low SHALL asynchronously clear all registers to 0 except %rsp=RSP_RESET, and set ZF=1, SF=0, OF=0.
REQ-025 Writes coinciding with active reset SHALL be discarded.

Configuration
REQ-026 With RF_DUMP_EN defined: extra output rf_dump (960 bits, register i at bits [64i+63:64i]); without it the port and its logic are absent.

Structure
REQ-027 Shared package y86_pkg SHALL hold icode/ifun constants, condition codes, register IDs (RSP=4, RNONE=15).
REQ-028 Register file SHALL be a sub-module y86_regfile (2 async read, 2 sync write ports).

Verification
REQ-029 Reset then icode=3, rB=2, valC=120, clock -> register 2 = 120, PC_next=valP.
REQ-030 Regs 1=100, 5=4; icode=6, ifun=0, rA=1, rB=5 -> valE=104, after edge reg5=104, ZF=0, SF=0, OF=0.
REQ-031 Sub 0x8000...0 minus 1 (valB=min, valA=1) -> OF=1, SF=0; then icode=7, ifun=2 -> Cnd=1, PC_next=valC.
REQ-032 %rsp=200; icode=A -> valE=192, %rsp=192 after edge; icode=B, valM=5, rA=3 -> reg3=5, %rsp=200.
REQ-033 icode=8, valC=80 -> PC_next=80, %rsp-=8; icode=9, valM=69 -> PC_next=69.
REQ-034 icode=2, ifun=6 with ZF=1 -> Cnd=0, rB unchanged; rst_n low mid-sequence -> all state at reset values immediately.
